radix2_butterfly_pipe: RTL and testbench
========================================

Name: radix2_butterfly_pipe

Overview:
- Parametrised, pipelined radix-2 DIF butterfly for the FFT datapath.
- Computes y0 = x0 + x1 and y1 = (x0 − x1)·W for one complex pair per cycle.
- W is a runtime twiddle input, so one block serves every FFT stage instead of fixed-twiddle butterflies.
- Adds rounding, saturation, optional per-sample ½ scaling, inverse-transform mode (conjugate twiddle), a valid pipeline with global stall, and a sticky overflow flag.

Parameters:
- DW, 32, width of each real/imag component (signed fixed point)
- FRAC, 16, fractional bits of data and twiddle (Q(DW−FRAC).FRAC)
- LAT, 3, pipeline latency in enabled cycles; fixed, not overridable (documentation constant)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  pipeline advance; 0 freezes every register
- in_valid  in  1  x0/x1/tw/inv/scale valid this cycle
- x0  in  2*DW  {real, imag} operand 0
- x1  in  2*DW  {real, imag} operand 1
- tw  in  2*DW  {real, imag} twiddle, same Q format
- inv  in  1  1 = use conj(tw) (IFFT)
- scale  in  1  1 = divide both outputs by 2 with rounding
- ovf_clr  in  1  synchronous clear of ovf
- out_valid  out  1  y0/y1 valid
- y0  out  2*DW  {real, imag} sum output
- y1  out  2*DW  {real, imag} twiddled difference output
- ovf  out  1  sticky saturation flag

Behaviour:
- Reset (rst=0, async): all pipeline registers, out_valid, y0, y1 and ovf go to 0. Any in-flight samples are discarded. The first valid output comes no earlier than LAT enabled cycles after release.
- en=1: all stages advance one step. en=0: all stages, including out_valid, y0, y1 and ovf, hold their values. The ovf_clr and ovf-set logic is also gated by en.
- Inputs are sampled on any clock edge with en=1. A sample with in_valid=0 propagates as a bubble, and its out_valid=0.
- S1:
  - sr = x0r+x1r, si = x0i+x1i, dr = x0r−x1r, di = x0i−x1i, each DW+1 bits sign-extended.
  - Register twi = inv ? −tw_i : tw_i. Negating −2^(DW−1) saturates to 2^(DW−1)−1.
  - Register twr, scale and valid.
- S2:
  - pr = dr·twr − di·twi and pi = dr·twi + di·twr, full precision (2*DW+2 bits).
  - Delay sr/si, scale and valid by one stage.
- S3, rounding (shift k = FRAC + scale):
  - Products: add 2^(k−1), then arithmetic right shift by k (round half toward +inf).
  - Sums: when scale=1, add 1 and then arithmetic shift right by 1; when scale=0, pass unchanged.
- S3, saturation:
  - Clamp each of the four results to [−2^(DW−1), 2^(DW−1)−1].
  - If any component clamps and valid=1, set ovf to 1. It stays 1 until cleared.
  - ovf_clr=1 with en=1 clears ovf. If a new clamp happens in the same cycle, set wins.
- Output: y0 = {sr', si'}, y1 = {pr', pi'}, out_valid = S3 valid. Total latency is 3 enabled cycles.
- Bubbles never change ovf. Data registers may update on bubbles, but the bench checks y0/y1 only when out_valid=1.
- Back-to-back valid samples give one result per enabled cycle, in order, with no gaps.

Test Plan:
- Reset and latency:
  - Stimulus: hold rst=0 mid-stream, then release, then apply one valid sample with en=1.
  - Response: out_valid, y0, y1 and ovf read 0 during reset. out_valid=1 exactly 3 edges after sampling.
- Twiddle 1:
  - Stimulus: tw=(0x00010000, 0), x0=(0x00030000, 0x00010000), x1=(0x00010000, 0x00020000), inv=0, scale=0.
  - Response: y0=(0x00040000, 0x00030000), y1=(0x00020000, 0xFFFF0000).
- Twiddle −j and inverse mode:
  - Stimulus: same x0/x1, tw=(0, 0xFFFF0000).
  - Response with inv=0: y1=(0xFFFF0000, 0xFFFE0000).
  - Response with inv=1: y1=(0x00010000, 0x00020000).
- Rounding and scale:
  - Stimulus: x0=(1, 0), x1=0, tw=(0x00008000, 0).
  - Response: y1=(0x00000001, 0). With scale=1 and x0=(0x00030001, 0): y0=(0x00018001, 0).
- Saturation and ovf:
  - Stimulus: x0r=x1r=0x7FFF0000, scale=0.
  - Response: y0r=0x7FFFFFFF and ovf=1, held through later clean samples until ovf_clr.
  - With scale=1: y0r=0x7FFF0000 and ovf stays 0.
- Stall:
  - Stimulus: 4 back-to-back valid samples with en dropped for 2 cycles mid-stream.
  - Response: outputs frozen during the stall, all 4 results in order, none lost or duplicated.

Source files
------------

// File: rtl/radix2_butterfly_pipe_if.sv
// Bundle of the butterfly's stream signals: enable, operands, mode bits,
// results and the sticky overflow flag. The master drives operands, the
// slave (the butterfly) drives results.
interface radix2_butterfly_pipe_if #(
  parameter int DW = 32
);
  logic          en;
  logic          in_valid;
  logic [2*DW-1:0] x0;
  logic [2*DW-1:0] x1;
  logic [2*DW-1:0] tw;
  logic          inv;
  logic          scale;
  logic          ovf_clr;
  logic          out_valid;
  logic [2*DW-1:0] y0;
  logic [2*DW-1:0] y1;
  logic          ovf;

  modport master (
    output en, in_valid, x0, x1, tw, inv, scale, ovf_clr,
    input  out_valid, y0, y1, ovf
  );

  modport slave (
    input  en, in_valid, x0, x1, tw, inv, scale, ovf_clr,
    output out_valid, y0, y1, ovf
  );
endinterface

// File: rtl/radix2_butterfly_pipe.sv
// Pipelined radix-2 DIF butterfly: y0 = x0 + x1, y1 = (x0 - x1) * W, with a
// runtime twiddle, conjugate (inverse) mode, optional /2 scaling, rounding,
// saturation and a sticky overflow flag. Three enabled cycles of latency;
// en=0 freezes every register. The interface DW must match the module DW.
module radix2_butterfly_pipe #(
  parameter int DW   = 32,
  parameter int FRAC = 16
) (
  input logic                      clk,
  input logic                      rst,
  radix2_butterfly_pipe_if.slave   bif
);

  localparam int LAT = 3;
  localparam int SW  = DW + 1;
  localparam int PW  = 2 * DW + 2;

  // Negate with the single unrepresentable case (-2^(DW-1)) clamped to max.
  function automatic logic signed [DW-1:0] neg_sat(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] mn;
    mn = '0;
    mn[DW-1] = 1'b1;
    if (v == mn) return ~mn;
    return -v;
  endfunction

  // Product rounding: add half an LSB of the target, shift by FRAC (+1 when scaling).
  function automatic logic signed [PW-1:0] rnd_prod(input logic signed [PW-1:0] p,
                                                   input logic sc);
    logic signed [PW-1:0] half;
    logic signed [PW-1:0] t;
    half = '0;
    if (sc) half[FRAC] = 1'b1;
    else    half[FRAC-1] = 1'b1;
    t = p + half;
    return sc ? (t >>> (FRAC + 1)) : (t >>> FRAC);
  endfunction

  // Sum scaling: (s + 1) >>> 1 when halving, untouched otherwise.
  function automatic logic signed [SW-1:0] rnd_sum(input logic signed [SW-1:0] s,
                                                  input logic sc);
    logic signed [SW-1:0] t;
    t = s + {{(SW-1){1'b0}}, 1'b1};
    return sc ? (t >>> 1) : s;
  endfunction

  // Clamp to DW bits; MSB of the result flags that clamping occurred.
  function automatic logic [DW:0] sat_chk(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    hi = '0;
    hi[DW-2:0] = '1;
    lo = '1;
    lo[DW-2:0] = '0;
    if (v > hi)      return {1'b1, hi[DW-1:0]};
    else if (v < lo) return {1'b1, lo[DW-1:0]};
    return {1'b0, v[DW-1:0]};
  endfunction

  // Operand views
  logic signed [DW-1:0] x0r, x0i, x1r, x1i, twr_in, twi_in;
  assign x0r    = bif.x0[2*DW-1:DW];
  assign x0i    = bif.x0[DW-1:0];
  assign x1r    = bif.x1[2*DW-1:DW];
  assign x1i    = bif.x1[DW-1:0];
  assign twr_in = bif.tw[2*DW-1:DW];
  assign twi_in = bif.tw[DW-1:0];

  // Valid shift register: bit n is the valid of stage n+1
  logic [LAT-1:0] vld_d, vld_q;

  // ---- stage 1: sums, differences, conditioned twiddle
  logic signed [SW-1:0] sr_p1_d, si_p1_d, dr_p1_d, di_p1_d;
  logic signed [SW-1:0] sr_p1_q, si_p1_q, dr_p1_q, di_p1_q;
  logic signed [DW-1:0] twr_p1_d, twi_p1_d, twr_p1_q, twi_p1_q;
  logic                 sc_p1_q;

  always_comb begin
    sr_p1_d  = {x0r[DW-1], x0r} + {x1r[DW-1], x1r};
    si_p1_d  = {x0i[DW-1], x0i} + {x1i[DW-1], x1i};
    dr_p1_d  = {x0r[DW-1], x0r} - {x1r[DW-1], x1r};
    di_p1_d  = {x0i[DW-1], x0i} - {x1i[DW-1], x1i};
    twr_p1_d = twr_in;
    twi_p1_d = bif.inv ? neg_sat(twi_in) : twi_in;
    vld_d    = {vld_q[LAT-2:0], bif.in_valid};
  end

  // Stage 1 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_p1_q  <= '0;
      si_p1_q  <= '0;
      dr_p1_q  <= '0;
      di_p1_q  <= '0;
      twr_p1_q <= '0;
      twi_p1_q <= '0;
      sc_p1_q  <= 1'b0;
      vld_q    <= '0;
    end else if (bif.en) begin
      sr_p1_q  <= sr_p1_d;
      si_p1_q  <= si_p1_d;
      dr_p1_q  <= dr_p1_d;
      di_p1_q  <= di_p1_d;
      twr_p1_q <= twr_p1_d;
      twi_p1_q <= twi_p1_d;
      sc_p1_q  <= bif.scale;
      vld_q    <= vld_d;
    end
  end

  // ---- stage 2: full-precision complex multiply
  logic signed [PW-1:0] pr_p2_d, pi_p2_d, pr_p2_q, pi_p2_q;
  logic signed [SW-1:0] sr_p2_q, si_p2_q;
  logic                 sc_p2_q;

  always_comb begin
    pr_p2_d = PW'(dr_p1_q) * PW'(twr_p1_q) - PW'(di_p1_q) * PW'(twi_p1_q);
    pi_p2_d = PW'(dr_p1_q) * PW'(twi_p1_q) + PW'(di_p1_q) * PW'(twr_p1_q);
  end

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pr_p2_q <= '0;
      pi_p2_q <= '0;
      sr_p2_q <= '0;
      si_p2_q <= '0;
      sc_p2_q <= 1'b0;
    end else if (bif.en) begin
      pr_p2_q <= pr_p2_d;
      pi_p2_q <= pi_p2_d;
      sr_p2_q <= sr_p1_q;
      si_p2_q <= si_p1_q;
      sc_p2_q <= sc_p1_q;
    end
  end

  // ---- stage 3: rounding, saturation, overflow flag
  logic signed [SW-1:0] sr_rnd, si_rnd;
  logic signed [PW-1:0] pr_rnd, pi_rnd;
  logic [DW:0]          sat_sr, sat_si, sat_pr, sat_pi;
  logic                 clamp_any;
  logic                 ovf_d, ovf_q;
  logic [DW-1:0]        y0r_q, y0i_q, y1r_q, y1i_q;

  always_comb begin
    sr_rnd    = rnd_sum(sr_p2_q, sc_p2_q);
    si_rnd    = rnd_sum(si_p2_q, sc_p2_q);
    pr_rnd    = rnd_prod(pr_p2_q, sc_p2_q);
    pi_rnd    = rnd_prod(pi_p2_q, sc_p2_q);
    sat_sr    = sat_chk(PW'(sr_rnd));
    sat_si    = sat_chk(PW'(si_rnd));
    sat_pr    = sat_chk(pr_rnd);
    sat_pi    = sat_chk(pi_rnd);
    clamp_any = sat_sr[DW] | sat_si[DW] | sat_pr[DW] | sat_pi[DW];
    ovf_d     = ovf_q;
    if (bif.ovf_clr)            ovf_d = 1'b0;
    if (vld_q[1] && clamp_any)  ovf_d = 1'b1;
  end

  // Output registers and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y0r_q <= '0;
      y0i_q <= '0;
      y1r_q <= '0;
      y1i_q <= '0;
      ovf_q <= 1'b0;
    end else if (bif.en) begin
      y0r_q <= sat_sr[DW-1:0];
      y0i_q <= sat_si[DW-1:0];
      y1r_q <= sat_pr[DW-1:0];
      y1i_q <= sat_pi[DW-1:0];
      ovf_q <= ovf_d;
    end
  end

  assign bif.out_valid = vld_q[LAT-1];
  assign bif.y0        = {y0r_q, y0i_q};
  assign bif.y1        = {y1r_q, y1i_q};
  assign bif.ovf       = ovf_q;

endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// Directed bench for radix2_butterfly_pipe: vector table plus hand-written
// sequences for reset, overflow stickiness and stall behaviour.
module tb_radix2_butterfly_pipe;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  radix2_butterfly_pipe_if #(.DW(DW)) bif ();

  radix2_butterfly_pipe #(.DW(DW), .FRAC(16)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  typedef struct {
    string       name;
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] tw;
    logic        inv;
    logic        scale;
    logic [63:0] y0;
    logic [63:0] y1;
  } vec_t;

  vec_t        vecs [11];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] q_y0 [$];
  logic [63:0] q_y1 [$];

  function automatic vec_t mk(input string n, input logic [63:0] x0, input logic [63:0] x1,
                              input logic [63:0] tw, input logic inv, input logic sc,
                              input logic [63:0] y0, input logic [63:0] y1);
    vec_t v;
    v.name = n; v.x0 = x0; v.x1 = x1; v.tw = tw;
    v.inv = inv; v.scale = sc; v.y0 = y0; v.y1 = y1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock with the given enable; results seen on enabled edges are queued.
  task automatic step(input logic e);
    bif.en = e;
    @(posedge clk);
    #1;
    if (e && bif.out_valid) begin
      q_y0.push_back(bif.y0);
      q_y1.push_back(bif.y1);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    bif.x0       = v.x0;
    bif.x1       = v.x1;
    bif.tw       = v.tw;
    bif.inv      = v.inv;
    bif.scale    = v.scale;
    bif.in_valid = vld;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v, 1'b1);
    step(1'b1);
    bif.in_valid = 1'b0;
    step(1'b1);
    step(1'b1);
    chk({v.name, " out_valid"}, 64'(bif.out_valid), 64'd1);
    chk({v.name, " y0"}, bif.y0, v.y0);
    chk({v.name, " y1"}, bif.y1, v.y1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sp1, sp0, sn, sv;
    vec_t stv [4];
    int   seen;

    vecs[0]  = mk("tw1",      64'h00030000_00010000, 64'h00010000_00020000, 64'h00010000_00000000, 0, 0,
                  64'h00040000_00030000, 64'h00020000_FFFF0000);
    vecs[1]  = mk("tw_mj",    64'h00030000_00010000, 64'h00010000_00020000, 64'h00000000_FFFF0000, 0, 0,
                  64'h00040000_00030000, 64'hFFFF0000_FFFE0000);
    vecs[2]  = mk("tw_mj_inv",64'h00030000_00010000, 64'h00010000_00020000, 64'h00000000_FFFF0000, 1, 0,
                  64'h00040000_00030000, 64'h00010000_00020000);
    vecs[3]  = mk("rnd_half", 64'h00000001_00000000, 64'h0, 64'h00008000_00000000, 0, 0,
                  64'h00000001_00000000, 64'h00000001_00000000);
    vecs[4]  = mk("rnd_scale",64'h00030001_00000000, 64'h0, 64'h00008000_00000000, 0, 1,
                  64'h00018001_00000000, 64'h0000C000_00000000);
    vecs[5]  = mk("twneg_inv",64'h00010000_00000000, 64'h0, 64'h00000000_80000000, 1, 0,
                  64'h00010000_00000000, 64'h00000000_7FFFFFFF);
    vecs[6]  = mk("twneg",    64'h00010000_00000000, 64'h0, 64'h00000000_80000000, 0, 0,
                  64'h00010000_00000000, 64'h00000000_80000000);
    vecs[7]  = mk("rnd_neg",  64'hFFFFFFFF_00000000, 64'h0, 64'h00008000_00000000, 0, 0,
                  64'hFFFFFFFF_00000000, 64'h0);
    vecs[8]  = mk("sum_neg_sc",64'hFFFFFFFD_00000000, 64'h0, 64'h0, 0, 1,
                  64'hFFFFFFFF_00000000, 64'h0);
    vecs[9]  = mk("cplx",     64'h00020000_00010000, 64'h00008000_FFFF0000, 64'h00008000_00008000, 0, 0,
                  64'h00028000_00000000, 64'hFFFFC000_0001C000);
    vecs[10] = mk("cplx_inv", 64'h00020000_00010000, 64'h00008000_FFFF0000, 64'h00008000_00008000, 1, 0,
                  64'h00028000_00000000, 64'h0001C000_00004000);

    bif.en = 1'b1; bif.ovf_clr = 1'b0;
    drive(vecs[0], 1'b1);

    // Reset held with valid traffic presented
    step(1'b1);
    step(1'b1);
    chk("rst out_valid", 64'(bif.out_valid), 64'd0);
    chk("rst y0", bif.y0, 64'd0);
    chk("rst y1", bif.y1, 64'd0);
    chk("rst ovf", 64'(bif.ovf), 64'd0);
    rst = 1'b1;
    bif.in_valid = 1'b0;
    step(1'b1);

    // Latency of one sample
    drive(vecs[0], 1'b1);
    step(1'b1);
    bif.in_valid = 1'b0;
    chk("lat edge1", 64'(bif.out_valid), 64'd0);
    step(1'b1);
    chk("lat edge2", 64'(bif.out_valid), 64'd0);
    step(1'b1);
    chk("lat edge3", 64'(bif.out_valid), 64'd1);
    chk("lat y0", bif.y0, vecs[0].y0);

    // Reset mid-stream discards in-flight samples
    drive(vecs[9], 1'b1);
    step(1'b1); step(1'b1); step(1'b1);
    chk("mid pre vld", 64'(bif.out_valid), 64'd1);
    #3 rst = 1'b0;
    #1;
    chk("mid async vld", 64'(bif.out_valid), 64'd0);
    chk("mid async y0", bif.y0, 64'd0);
    chk("mid async y1", bif.y1, 64'd0);
    step(1'b1); step(1'b1);
    rst = 1'b1;
    bif.in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      if (bif.out_valid) seen++;
    end
    chk("mid discarded", 64'(seen), 64'd0);

    // Vector table
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);
    chk("table ovf", 64'(bif.ovf), 64'd0);

    // Saturation and sticky overflow
    sp1 = mk("sat_sc1", 64'h7FFF0000_00000000, 64'h7FFF0000_00000000, 64'h00010000_00000000, 0, 1,
             64'h7FFF0000_00000000, 64'h0);
    sp0 = mk("sat_pos", 64'h7FFF0000_00000000, 64'h7FFF0000_00000000, 64'h00010000_00000000, 0, 0,
             64'h7FFFFFFF_00000000, 64'h0);
    sn  = mk("sat_neg", 64'h80000000_00000000, 64'h80000000_00000000, 64'h00010000_00000000, 0, 0,
             64'h80000000_00000000, 64'h0);
    run_vec(sp1);
    chk("sat_sc1 ovf", 64'(bif.ovf), 64'd0);
    run_vec(sp0);
    chk("sat_pos ovf", 64'(bif.ovf), 64'd1);
    run_vec(vecs[0]);
    chk("ovf sticky", 64'(bif.ovf), 64'd1);
    bif.ovf_clr = 1'b1;
    step(1'b0);
    chk("ovf clr stalled", 64'(bif.ovf), 64'd1);
    step(1'b1);
    chk("ovf clr", 64'(bif.ovf), 64'd0);
    bif.ovf_clr = 1'b0;
    drive(sp0, 1'b0);
    step(1'b1); step(1'b1); step(1'b1);
    chk("bubble vld", 64'(bif.out_valid), 64'd0);
    chk("bubble ovf", 64'(bif.ovf), 64'd0);
    drive(sn, 1'b1);
    step(1'b1);
    bif.in_valid = 1'b0;
    step(1'b1);
    bif.ovf_clr = 1'b1;
    step(1'b1);
    bif.ovf_clr = 1'b0;
    chk("sat_neg vld", 64'(bif.out_valid), 64'd1);
    chk("sat_neg y0", bif.y0, sn.y0);
    chk("set wins ovf", 64'(bif.ovf), 64'd1);
    bif.ovf_clr = 1'b1;
    step(1'b1);
    bif.ovf_clr = 1'b0;

    // Stall in the middle of a back-to-back burst
    for (int k = 0; k < 4; k++) begin
      sv = mk("stall", {32'(k + 2) << 16, 32'h0}, 64'h00010000_00000000, 64'h00010000_00000000, 0, 0,
              {32'(k + 3) << 16, 32'h0}, {32'(k + 1) << 16, 32'h0});
      stv[k] = sv;
    end
    q_y0.delete();
    q_y1.delete();
    for (int k = 0; k < 3; k++) begin
      drive(stv[k], 1'b1);
      step(1'b1);
    end
    drive(stv[3], 1'b1);
    for (int s = 0; s < 2; s++) begin
      step(1'b0);
      chk("stall vld", 64'(bif.out_valid), 64'd1);
      chk("stall y0", bif.y0, stv[0].y0);
      chk("stall y1", bif.y1, stv[0].y1);
    end
    step(1'b1);
    bif.in_valid = 1'b0;
    for (int s = 0; s < 6; s++) step(1'b1);
    chk("stall count", 64'(q_y0.size()), 64'd4);
    for (int k = 0; k < 4 && k < q_y0.size(); k++) begin
      chk("stall order y0", q_y0[k], stv[k].y0);
      chk("stall order y1", q_y1[k], stv[k].y1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
